// File: rtl/i2s_receiver_if.sv
// i2s_receiver_if: valid/ready word output of the I2S receiver.
// master = receiver side, slave = downstream consumer.
interface i2s_receiver_if #(
  parameter int BITS = 16
);
  logic [BITS-1:0] o_data;
  logic            o_ws;
  logic            o_valid;
  logic            o_ready;

  modport master (
    output o_data,
    output o_ws,
    output o_valid,
    input  o_ready
  );

  modport slave (
    input  o_data,
    input  o_ws,
    input  o_valid,
    output o_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S bit stream to parallel words, valid/ready output.
// Define I2S_RECEIVER_FIFO_EN for a 4-entry output FIFO instead of one register.
module i2s_receiver #(
  parameter int BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic overrun,
  i2s_receiver_if.master m
);
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [1:0] sck_q, ws_q, sd_q;
  logic sck_prev_q;
  logic ws_prev_q, ws_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] sh_q, sh_d;
  logic tag_q, tag_d;
  logic ovr_q, ovr_d;
  logic ev, wchg, push, pop, full, wr;

  assign ev        = sck_q[1] & ~sck_prev_q;
  assign wchg      = ev & (ws_q[1] ^ ws_prev_q);
  assign ws_prev_d = ev ? ws_q[1] : ws_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q      <= '0;
      ws_q       <= '0;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
      ws_prev_q  <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tag_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck};
      ws_q       <= {ws_q[0], ws};
      sd_q       <= {sd_q[0], sd};
      sck_prev_q <= sck_q[1];
      ws_prev_q  <= ws_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tag_q      <= tag_d;
      ovr_q      <= ovr_d;
    end
  end

  // A ws change restarts a word from any state; its own sd bit is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tag_d   = tag_q;
    push    = 1'b0;
    if (wchg) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      tag_d   = ws_q[1];
    end else if (ev) begin
      case (state_q)
        S_SHIFT: begin
          sh_d  = {sh_q[BITS-2:0], sd_q[1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BITS)) begin
            push    = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop     = m.o_valid & m.o_ready;
  assign ovr_d   = push & full & ~pop;
  assign wr      = push & ~ovr_d;
  assign overrun = ovr_q;

`ifdef I2S_RECEIVER_FIFO_EN
  logic [BITS:0] mem_q [4];
  logic [1:0] rd_q, wr_q;
  logic [2:0] n_q;

  assign full      = n_q[2];
  assign m.o_valid = (n_q != 3'd0);
  assign m.o_data  = m.o_valid ? mem_q[rd_q][BITS-1:0] : '0;
  assign m.o_ws    = m.o_valid & mem_q[rd_q][BITS];

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= {tag_q, sh_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      n_q  <= '0;
    end else begin
      if (wr) wr_q <= wr_q + 2'd1;
      if (pop) rd_q <= rd_q + 2'd1;
      n_q <= n_q + {2'b0, wr} - {2'b0, pop};
    end
  end
`else
  logic [BITS-1:0] data_q;
  logic ws_o_q, val_q;

  assign full      = val_q;
  assign m.o_valid = val_q;
  assign m.o_data  = data_q;
  assign m.o_ws    = ws_o_q;

  // data/tag are zeroed on pop so o_data reads 0 while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= 1'b0;
      ws_o_q <= 1'b0;
      data_q <= '0;
    end else if (wr) begin
      val_q  <= 1'b1;
      ws_o_q <= tag_q;
      data_q <= sh_d;
    end else if (pop) begin
      val_q  <= 1'b0;
      ws_o_q <= 1'b0;
      data_q <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized I2S stimulus checked every cycle against a
// word-level model (bit queues + storage queue), plus directed literal checks.
module tb_i2s_receiver;
  localparam int BITS = 16;
`ifdef I2S_RECEIVER_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic ws  = 1'b0;
  logic sd  = 1'b0;
  logic overrun;

  i2s_receiver_if #(.BITS(BITS)) bus ();

  i2s_receiver #(.BITS(BITS)) dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .ws(ws),
    .sd(sd),
    .overrun(overrun),
    .m(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [BITS:0] mq[$];
  logic [BITS:0] xlog[$];
  int            pend_cyc[$];
  logic [BITS:0] pend_w[$];
  logic m_ovr = 1'b0;
  int   ovr_cnt = 0;
  int   last_push = -10;

  logic m_wsprev = 1'b0;
  bit   armed = 1'b0;
  logic m_tag = 1'b0;
  bit   bq[$];

  int rdy_mode = 0;
  bit rdy_const = 1'b0;
  int hp = 4;
  logic cur_ws = 1'b0;

  // One sampling point: ws change opens a word, next BITS bits fill it.
  // Storage sees it three clk edges after the bench raises sck.
  function automatic void model_rise(input logic w, input logic d);
    logic [BITS-1:0] v;
    if (w != m_wsprev) begin
      armed = 1'b1;
      m_tag = w;
      bq.delete();
    end else if (armed) begin
      bq.push_back(d);
      if (bq.size() == BITS) begin
        v = '0;
        foreach (bq[i]) v = (v << 1) | BITS'(bq[i]);
        pend_cyc.push_back(cyc + 3);
        pend_w.push_back({m_tag, v});
        last_push = cyc + 3;
        armed = 1'b0;
      end
    end
    m_wsprev = w;
  endfunction

  always @(posedge clk) begin
    bit pop, psh;
    logic [BITS:0] pw;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      pend_cyc.delete();
      pend_w.delete();
      bq.delete();
      m_ovr = 1'b0;
      m_wsprev = 1'b0;
      armed = 1'b0;
    end else begin
      pop = bus.o_ready && (mq.size() > 0);
      psh = 1'b0;
      pw  = '0;
      if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
        psh = 1'b1;
        pw  = pend_w.pop_front();
        void'(pend_cyc.pop_front());
      end
      if (pop) xlog.push_back(mq.pop_front());
      m_ovr = 1'b0;
      if (psh) begin
        if (mq.size() < CAP) mq.push_back(pw);
        else begin
          m_ovr = 1'b1;
          ovr_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic ev, ew;
    logic [BITS-1:0] ed;
    if (cyc > 0) begin
      ev = (mq.size() > 0);
      ed = ev ? mq[0][BITS-1:0] : '0;
      ew = ev ? mq[0][BITS] : 1'b0;
      vectors++;
      if (bus.o_valid !== ev || bus.o_data !== ed ||
          bus.o_ws !== ew || overrun !== m_ovr) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL cycle %0d: dut v=%b ws=%b d=%h ovr=%b, want v=%b ws=%b d=%h ovr=%b",
                   cyc, bus.o_valid, bus.o_ws, bus.o_data, overrun,
                   ev, ew, ed, m_ovr);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      1:       bus.o_ready = 1'($urandom_range(0, 1));
      2:       bus.o_ready = (cyc == last_push - 1);
      default: bus.o_ready = rdy_const;
    endcase
  endtask

  task automatic sbit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    repeat (hp) tick();
    sck = 1'b1;
    model_rise(w, d);
    repeat (hp) tick();
  endtask

  task automatic send_half(input logic w, input logic [23:0] val,
                           input int dbits, input int total);
    bit b;
    for (int i = 0; i < total; i++) begin
      if (i == 0 || i > dbits) b = 1'($urandom_range(0, 1));
      else b = val[dbits-i];
      sbit(w, b);
    end
    cur_ws = w;
  endtask

  task automatic idle(input int n);
    sck = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int base, o0, n_exp;
    logic [BITS:0] w_exp;
    bus.o_ready = 1'b0;
    rst = 1'b1;
    repeat (4) tick();
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd0);
    check("rst_ws", 32'(bus.o_ws), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(4);

    // stereo frame, always ready
    rdy_const = 1'b1;
    base = xlog.size();
    o0 = ovr_cnt;
    send_half(1'b1, 24'h0, 0, 5);
    send_half(1'b0, 24'hA5C3, 16, 32);
    send_half(1'b1, 24'h1234, 16, 32);
    idle(10);
    check("frame_n", 32'(xlog.size() - base), 32'd2);
    check("frame_w0", 32'(xlog[base]), {15'd0, 1'b0, 16'hA5C3});
    check("frame_w1", 32'(xlog[base+1]), {15'd0, 1'b1, 16'h1234});
    check("frame_ovr", 32'(ovr_cnt - o0), 32'd0);

    // back-pressure across two words
    rdy_const = 1'b0;
    base = xlog.size();
    o0 = ovr_cnt;
    send_half(1'b0, 24'h1111, 16, 32);
    send_half(1'b1, 24'h2222, 16, 32);
    idle(10);
    check("bp_hold_data", 32'(bus.o_data), 32'h1111);
    check("bp_hold_valid", 32'(bus.o_valid), 32'd1);
    check("bp_ovr", 32'(ovr_cnt - o0), (CAP == 1) ? 32'd1 : 32'd0);
    rdy_const = 1'b1;
    idle(10);
    n_exp = (CAP == 1) ? 1 : 2;
    w_exp = (CAP == 1) ? {1'b0, 16'h1111} : {1'b1, 16'h2222};
    check("bp_n", 32'(xlog.size() - base), 32'(n_exp));
    check("bp_first", 32'(xlog[base]), {15'd0, 1'b0, 16'h1111});
    check("bp_last", 32'(xlog[base+n_exp-1]), 32'(w_exp));

    // short word then full word
    base = xlog.size();
    send_half(1'b0, 24'h3FF, 10, 11);
    send_half(1'b1, 24'hBEEF, 16, 32);
    idle(10);
    check("short_n", 32'(xlog.size() - base), 32'd1);
    check("short_w", 32'(xlog[base]), {15'd0, 1'b1, 16'hBEEF});

    // 24-bit transmitter into 16-bit receiver
    base = xlog.size();
    send_half(1'b0, 24'hABCDEF, 24, 24);
    idle(10);
    check("long_n", 32'(xlog.size() - base), 32'd1);
    check("long_w", 32'(xlog[base]), {15'd0, 1'b0, 16'hABCD});

    // reset mid-word
    base = xlog.size();
    send_half(1'b1, 24'hC3C3, 16, 9);
    idle(4);
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_data", 32'(bus.o_data), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(4);
    send_half(1'b0, 24'h7777, 16, 32);
    send_half(1'b1, 24'h5A5A, 16, 32);
    idle(10);
    check("midrst_n", 32'(xlog.size() - base), 32'd1);
    check("midrst_w", 32'(xlog[base]), {15'd0, 1'b1, 16'h5A5A});

    // full storage, ready only in the completion cycle
    rdy_const = 1'b0;
    base = xlog.size();
    o0 = ovr_cnt;
    for (int i = 0; i < CAP; i++)
      send_half(~cur_ws, 24'(16'h1000 + i), 16, 32);
    rdy_mode = 2;
    send_half(~cur_ws, 24'h2468, 16, 32);
    idle(2);
    check("edge_n", 32'(xlog.size() - base), 32'd1);
    check("edge_w", 32'(xlog[base][BITS-1:0]), 32'h1000);
    check("edge_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("edge_head", 32'(bus.o_data),
          (CAP == 1) ? 32'h2468 : 32'h1001);
    rdy_mode = 0;
    rdy_const = 1'b1;
    idle(20);

    // randomized frames, random ready and sck rate
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      hp = $urandom_range(3, 5);
      send_half(($urandom_range(0, 7) == 0) ? cur_ws : ~cur_ws,
                24'($urandom), 16, $urandom_range(3, 34));
    end
    rdy_mode = 0;
    rdy_const = 1'b1;
    idle(30);
    check("drain_empty", 32'(bus.o_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
